// File: rtl/uart_tx_frame_if.sv
// TX FIFO read port seen by the UART transmitter.
// master = FIFO side, slave = transmitter side.
interface uart_tx_frame_if #(
    parameter int MAX_DATA_W = 8
);
    logic                  fifo_empty;
    logic [MAX_DATA_W-1:0] fifo_rd_data;
    logic                  fifo_rd_req;

    modport master (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_req
    );

    modport slave (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_req
    );
endinterface

// File: rtl/uart_tx_frame.sv
// Configurable UART transmitter fed from a synchronous TX FIFO.
// Frame config is latched once per frame in LOAD.
module uart_tx_frame #(
    parameter int MAX_DATA_W = 8,
    parameter int DIV_W      = 20,
    parameter int MIN_DIV    = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [3:0]       data_bits,
    input  logic [1:0]       parity_mode,
    input  logic             stop_two,
    uart_tx_frame_if.slave   fifo,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
    localparam logic [2:0] PARITY = 3'd5;
    localparam logic [2:0] STOP   = 3'd6;

    logic [2:0]            state;
    logic [DIV_W-1:0]      cnt;
    logic [DIV_W-1:0]      div_q;
    logic [3:0]            n_q;
    logic [3:0]            bit_idx;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;
    logic                  stop_idx;
    logic [MAX_DATA_W-1:0] shreg;

    logic [DIV_W-1:0]      div_in;
    logic [3:0]            n_in;
    logic                  par_x;
    logic                  par_in;
    logic                  cnt_end;
    logic                  last_stop;

    // Clamped config and parity of the word arriving in LOAD
    always_comb begin
        div_in = baud_div;
        if (baud_div < DIV_W'(MIN_DIV))
            div_in = DIV_W'(MIN_DIV);
        n_in = data_bits;
        if (data_bits < 4'd5)
            n_in = 4'd5;
        else if (data_bits > 4'(MAX_DATA_W))
            n_in = 4'(MAX_DATA_W);
        par_x = 1'b0;
        for (int i = 0; i < MAX_DATA_W; i++)
            if (4'(i) < n_in)
                par_x = par_x ^ fifo.fifo_rd_data[i];
        case (parity_mode)
            2'b01:   par_in = ~par_x;
            2'b10:   par_in = par_x;
            default: par_in = 1'b1;
        endcase
    end

    assign cnt_end   = (cnt == div_q - DIV_W'(1));
    assign last_stop = (state == STOP) && cnt_end &&
                       (stop_idx == stop2_q);

    assign fifo.fifo_rd_req = (state == FETCH);
    assign busy             = (state != IDLE);
    assign frame_done       = last_stop;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            div_q     <= '0;
            n_q       <= '0;
            bit_idx   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            tx        <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!fifo.fifo_empty)
                        state <= FETCH;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    shreg     <= fifo.fifo_rd_data;
                    div_q     <= div_in;
                    n_q       <= n_in;
                    par_en_q  <= (parity_mode != 2'b00);
                    par_bit_q <= par_in;
                    stop2_q   <= stop_two;
                    cnt       <= '0;
                    bit_idx   <= '0;
                    stop_idx  <= 1'b0;
                    tx        <= 1'b0;
                    state     <= START;
                end
                START, DATA, PARITY, STOP: begin
                    if (!cnt_end) begin
                        cnt <= cnt + DIV_W'(1);
                    end else begin
                        cnt <= '0;
                        case (state)
                            START: begin
                                tx    <= shreg[0];
                                shreg <= {1'b0, shreg[MAX_DATA_W-1:1]};
                                state <= DATA;
                            end
                            DATA: begin
                                if (bit_idx == n_q - 4'd1) begin
                                    tx    <= par_en_q ? par_bit_q : 1'b1;
                                    state <= par_en_q ? PARITY : STOP;
                                end else begin
                                    tx      <= shreg[0];
                                    shreg   <= {1'b0, shreg[MAX_DATA_W-1:1]};
                                    bit_idx <= bit_idx + 4'd1;
                                end
                            end
                            PARITY: begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                            default: begin
                                tx <= 1'b1;
                                // Streaming skips IDLE: next FETCH follows directly
                                if (stop_idx != stop2_q)
                                    stop_idx <= 1'b1;
                                else if (!fifo.fifo_empty)
                                    state <= FETCH;
                                else
                                    state <= IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with a small FIFO model.
// Frames are given as {stop, parity, data, start} vectors, bit 0 first.
module tb_uart_tx_frame;

    localparam int W  = 8;
    localparam int DW = 20;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [DW-1:0] baud_div;
    logic [3:0]    data_bits;
    logic [1:0]    parity_mode;
    logic          stop_two;
    logic          tx;
    logic          busy;
    logic          frame_done;

    uart_tx_frame_if #(.MAX_DATA_W(W)) fifo_if ();

    uart_tx_frame #(
        .MAX_DATA_W(W),
        .DIV_W     (DW),
        .MIN_DIV   (4)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .baud_div   (baud_div),
        .data_bits  (data_bits),
        .parity_mode(parity_mode),
        .stop_two   (stop_two),
        .fifo       (fifo_if),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    logic [W-1:0] mem [16];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int n_chk  = 0;
    int n_fail = 0;

    assign fifo_if.fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge sys_clk)
        if (fifo_if.fifo_rd_req) begin
            fifo_if.fifo_rd_data <= mem[rd_cnt[3:0]];
            rd_cnt <= rd_cnt + 1;
        end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        mem[wr_cnt[3:0]] = d;
        wr_cnt = wr_cnt + 1;
    endtask

    task automatic wait_start(input string tag, input int exp_n);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        chk({tag, "_start"}, 32'(n), 32'(exp_n));
    endtask

    // Entered at the first cycle of the start bit; leaves at the last stop cycle
    task automatic check_frame(input string tag, input logic [15:0] bits,
                               input int nb, input int div);
        int good;
        int dn;
        logic last_done;
        dn = 0;
        last_done = 1'b0;
        for (int b = 0; b < nb; b++) begin
            good = 0;
            for (int c = 0; c < div; c++) begin
                if (tx === bits[b] && busy === 1'b1)
                    good++;
                if (frame_done === 1'b1)
                    dn++;
                last_done = frame_done;
                if (!(b == nb - 1 && c == div - 1))
                    @(negedge sys_clk);
            end
            chk($sformatf("%s_bit%0d", tag, b), 32'(good), 32'(div));
        end
        chk({tag, "_done_cnt"}, 32'(dn), 32'd1);
        chk({tag, "_done_last"}, {31'd0, last_done}, 32'd1);
    endtask

    task automatic gap_chk(input string tag);
        @(negedge sys_clk);
        chk({tag, "_fetch"}, {29'd0, tx, busy, fifo_if.fifo_rd_req}, 32'h7);
        @(negedge sys_clk);
        chk({tag, "_load"}, {29'd0, tx, busy, fifo_if.fifo_rd_req}, 32'h6);
        @(negedge sys_clk);
        chk({tag, "_start"}, {31'd0, tx}, 32'd0);
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] d,
                           input logic [15:0] bits, input int nb,
                           input int div);
        push(d);
        wait_start(tag, 3);
        check_frame(tag, bits, nb, div);
        @(negedge sys_clk);
        chk({tag, "_idle"}, {30'd0, tx, busy}, 32'h2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int rq;
        baud_div    = 20'd4;
        data_bits   = 4'd8;
        parity_mode = 2'b00;
        stop_two    = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_out",
            {28'd0, tx, busy, frame_done, fifo_if.fifo_rd_req}, 32'h8);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("idle_out",
            {28'd0, tx, busy, frame_done, fifo_if.fifo_rd_req}, 32'h8);

        r0 = rd_cnt;
        push(8'hA5);
        chk("lat_c0_req", {31'd0, fifo_if.fifo_rd_req}, 32'd0);
        @(negedge sys_clk);
        chk("lat_c1", {29'd0, tx, busy, fifo_if.fifo_rd_req}, 32'h7);
        @(negedge sys_clk);
        chk("lat_c2", {29'd0, tx, busy, fifo_if.fifo_rd_req}, 32'h6);
        @(negedge sys_clk);
        chk("lat_c3_tx", {31'd0, tx}, 32'd0);
        check_frame("8n1", {1'b1, 8'hA5, 1'b0}, 10, 4);
        @(negedge sys_clk);
        chk("8n1_idle", {30'd0, tx, busy}, 32'h2);
        chk("8n1_reads", 32'(rd_cnt - r0), 32'd1);

        data_bits   = 4'd7;
        parity_mode = 2'b10;
        stop_two    = 1'b1;
        baud_div    = 20'd10;
        run_one("7e2", 8'hB5, {2'b11, 1'b0, 7'h35, 1'b0}, 11, 10);

        data_bits   = 4'd5;
        parity_mode = 2'b01;
        stop_two    = 1'b0;
        baud_div    = 20'd4;
        run_one("5o1_1f", 8'h1F, {1'b1, 1'b0, 5'h1F, 1'b0}, 8, 4);
        run_one("5o1_1e", 8'h1E, {1'b1, 1'b1, 5'h1E, 1'b0}, 8, 4);

        data_bits   = 4'd8;
        parity_mode = 2'b11;
        run_one("8m1", 8'h00, {1'b1, 1'b1, 8'h00, 1'b0}, 11, 4);

        parity_mode = 2'b00;
        r0 = rd_cnt;
        push(8'h3C);
        push(8'hC3);
        push(8'h81);
        wait_start("str0", 3);
        check_frame("str0", {1'b1, 8'h3C, 1'b0}, 10, 4);
        gap_chk("gap1");
        check_frame("str1", {1'b1, 8'hC3, 1'b0}, 10, 4);
        gap_chk("gap2");
        check_frame("str2", {1'b1, 8'h81, 1'b0}, 10, 4);
        @(negedge sys_clk);
        chk("str_busy_end", {31'd0, busy}, 32'd0);
        chk("str_reads", 32'(rd_cnt - r0), 32'd3);

        baud_div  = 20'd1;
        data_bits = 4'd3;
        run_one("clamp_lo", 8'hF5, {1'b1, 5'h15, 1'b0}, 7, 4);
        baud_div  = 20'd4;
        data_bits = 4'd15;
        run_one("clamp_hi", 8'h96, {1'b1, 8'h96, 1'b0}, 10, 4);

        data_bits = 4'd8;
        push(8'h5A);
        push(8'h66);
        wait_start("cfg0", 3);
        baud_div = 20'd8;
        stop_two = 1'b1;
        check_frame("cfg0", {1'b1, 8'h5A, 1'b0}, 10, 4);
        gap_chk("cfg_gap");
        check_frame("cfg1", {2'b11, 8'h66, 1'b0}, 11, 8);
        @(negedge sys_clk);
        chk("cfg_idle", {30'd0, tx, busy}, 32'h2);

        baud_div = 20'd4;
        stop_two = 1'b0;
        push(8'h00);
        wait_start("rst", 3);
        repeat (6) @(negedge sys_clk);
        chk("rst_pre_tx", {31'd0, tx}, 32'd0);
        sys_rst_n = 1'b0;
        #1;
        chk("rst_now", {30'd0, tx, busy}, 32'h2);
        r0 = rd_cnt;
        push(8'h77);
        rq = 0;
        repeat (5) begin
            @(negedge sys_clk);
            if (fifo_if.fifo_rd_req === 1'b1)
                rq++;
        end
        chk("rst_no_req", 32'(rq), 32'd0);
        chk("rst_no_read", 32'(rd_cnt - r0), 32'd0);
        sys_rst_n = 1'b1;
        wait_start("post_rst", 3);
        check_frame("post_rst", {1'b1, 8'h77, 1'b0}, 10, 4);
        @(negedge sys_clk);
        chk("post_rst_idle", {30'd0, tx, busy}, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
